contador_tempo: RTL

CONTADOR_TEMPO -- requirements
Module: contador_tempo

---
 rtl/contador_tempo_pkg.sv | 26 ++
 rtl/bcd_passo_segundo.sv | 71 +++++++
 rtl/contador_tempo.sv | 103 ++++++++++
 3 files changed

// File: rtl/contador_tempo_pkg.sv
// Shared constants and types for the mm:ss playback time counter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package contador_tempo_pkg;

    localparam int TICKS_PER_SEC_DEF = 3000;  // clk = 3 kHz
    localparam int MAX_MIN_DEF       = 99;

    // BCD digit limits
    localparam logic [3:0] BCD_MAX_UNI     = 4'd9;  // any units digit
    localparam logic [3:0] BCD_MAX_DEZ_SEG = 4'd5;  // seconds tens digit

    typedef enum logic {
        RUN   = 1'b0,
        APPLY = 1'b1
    } estado_t;

    // mm:ss as four BCD digits, most significant first
    typedef struct packed {
        logic [3:0] min_dez;
        logic [3:0] min_uni;
        logic [3:0] seg_dez;
        logic [3:0] seg_uni;
    } tempo_t;

endpackage

// File: rtl/bcd_passo_segundo.sv
// Next mm:ss for a +1 s or -1 s step, with saturation at 00:00 and MAX_MIN:59.
// Latency: purely combinational.
// Backpressure: n/a.
// Ports: i_atual current time, i_sobe 1=+1 s / 0=-1 s,
//        o_prox next time, o_satura next time sits on the bound in the step direction.
module bcd_passo_segundo
    import contador_tempo_pkg::*;
#(
    parameter int MAX_MIN = MAX_MIN_DEF
) (
    input  tempo_t i_atual,
    input  logic   i_sobe,
    output tempo_t o_prox,
    output logic   o_satura
);

    localparam tempo_t TEMPO_MAX = '{
        min_dez: 4'(MAX_MIN / 10),
        min_uni: 4'(MAX_MIN % 10),
        seg_dez: BCD_MAX_DEZ_SEG,
        seg_uni: BCD_MAX_UNI
    };
    localparam tempo_t TEMPO_ZERO = '0;

    always_comb begin
        o_prox = i_atual;
        if (i_sobe) begin
            if (i_atual != TEMPO_MAX) begin
                if (i_atual.seg_uni != BCD_MAX_UNI) begin
                    o_prox.seg_uni = i_atual.seg_uni + 4'd1;
                end else begin
                    o_prox.seg_uni = 4'd0;
                    if (i_atual.seg_dez != BCD_MAX_DEZ_SEG) begin
                        o_prox.seg_dez = i_atual.seg_dez + 4'd1;
                    end else begin
                        o_prox.seg_dez = 4'd0;
                        if (i_atual.min_uni != BCD_MAX_UNI) begin
                            o_prox.min_uni = i_atual.min_uni + 4'd1;
                        end else begin
                            o_prox.min_uni = 4'd0;
                            o_prox.min_dez = i_atual.min_dez + 4'd1;
                        end
                    end
                end
            end
        end else begin
            if (i_atual != TEMPO_ZERO) begin
                if (i_atual.seg_uni != 4'd0) begin
                    o_prox.seg_uni = i_atual.seg_uni - 4'd1;
                end else begin
                    o_prox.seg_uni = BCD_MAX_UNI;
                    if (i_atual.seg_dez != 4'd0) begin
                        o_prox.seg_dez = i_atual.seg_dez - 4'd1;
                    end else begin
                        o_prox.seg_dez = BCD_MAX_DEZ_SEG;
                        if (i_atual.min_uni != 4'd0) begin
                            o_prox.min_uni = i_atual.min_uni - 4'd1;
                        end else begin
                            o_prox.min_uni = BCD_MAX_UNI;
                            o_prox.min_dez = i_atual.min_dez - 4'd1;
                        end
                    end
                end
            end
        end
    end

    // A step that lands on (or stays at) the bound ends a jump early.
    assign o_satura = i_sobe ? (o_prox == TEMPO_MAX) : (o_prox == TEMPO_ZERO);

endmodule

// File: rtl/contador_tempo.sv
// Playback time counter mm:ss: advances once per second, applies signed jumps one second per cycle.
// Latency: tick updates digits on the prescaler wrap edge; an N-second jump takes N cycles after latch.
// Backpressure: jump_valid is ignored while busy=1; zera always wins.
// Ports: clk, reset (async active-low), count (playback enable), zera (sync clear),
//        jump_valid/time_adder (signed seconds), min_dez/min_uni/seg_dez/seg_uni (BCD), busy.
module contador_tempo
    import contador_tempo_pkg::*;
#(
    parameter int TICKS_PER_SEC = TICKS_PER_SEC_DEF,
    parameter int MAX_MIN       = MAX_MIN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       count,
    input  logic       zera,
    input  logic       jump_valid,
    input  logic [8:0] time_adder,
    output logic [3:0] min_dez,
    output logic [3:0] min_uni,
    output logic [3:0] seg_dez,
    output logic [3:0] seg_uni,
    output logic       busy
);

    localparam logic [11:0] PRESC_FIM = 12'(TICKS_PER_SEC - 1);

    estado_t     r_estado;
    logic [11:0] r_presc;
    logic [8:0]  r_resta;
    logic        r_sobe;
    tempo_t      r_tempo;
    logic        r_busy;

    logic        w_tick;
    logic        w_passo_sobe;
    logic        w_satura;
    logic [8:0]  w_mag;
    tempo_t      w_prox;

    assign w_tick       = (r_estado == RUN) && count && (r_presc == PRESC_FIM);
    // Ticks always count up; during a jump the latched sign picks the direction.
    assign w_passo_sobe = (r_estado == APPLY) ? r_sobe : 1'b1;
    // |time_adder| in 9 bits unsigned; -256 maps to 256.
    assign w_mag        = time_adder[8] ? (~time_adder + 9'd1) : time_adder;

    bcd_passo_segundo #(
        .MAX_MIN (MAX_MIN)
    ) u_passo (
        .i_atual  (r_tempo),
        .i_sobe   (w_passo_sobe),
        .o_prox   (w_prox),
        .o_satura (w_satura)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_estado <= RUN;
            r_presc  <= '0;
            r_resta  <= '0;
            r_sobe   <= 1'b1;
            r_tempo  <= '0;
            r_busy   <= 1'b0;
        end else if (zera) begin
            r_estado <= RUN;
            r_presc  <= '0;
            r_resta  <= '0;
            r_tempo  <= '0;
            r_busy   <= 1'b0;
        end else if (r_estado == APPLY) begin
            // Prescaler is left untouched so playback resumes mid-second.
            r_tempo <= w_prox;
            r_resta <= r_resta - 9'd1;
            if ((r_resta == 9'd1) || w_satura) begin
                r_estado <= RUN;
                r_busy   <= 1'b0;
                r_resta  <= '0;
            end
        end else begin
            if (count) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_tempo <= w_prox;
                end else begin
                    r_presc <= r_presc + 12'd1;
                end
            end
            // A tick on the same edge is applied first; the jump then starts from the ticked value.
            if (jump_valid && (time_adder != 9'd0)) begin
                r_resta  <= w_mag;
                r_sobe   <= ~time_adder[8];
                r_estado <= APPLY;
                r_busy   <= 1'b1;
            end
        end
    end

    assign min_dez = r_tempo.min_dez;
    assign min_uni = r_tempo.min_uni;
    assign seg_dez = r_tempo.seg_dez;
    assign seg_uni = r_tempo.seg_uni;
    assign busy    = r_busy;

endmodule
